// File: rtl/add_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_arbiter_pkg
//  Description : Shared width default, requester id type and pipeline records
//                for the two-requester pipelined adder arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_arbiter_pkg;

    localparam int c_w_default = 64;

    typedef logic id_t;

    // Records are sized for the widest supported operand; narrower W zero-extends.
    typedef struct packed {
        logic [c_w_default-1:0] a;
        logic [c_w_default-1:0] b;
        logic                   cin;
        id_t                    id;
    } s1_t;

    typedef struct packed {
        logic [c_w_default-1:0] s;
        logic                   cout;
`ifdef ADD_ARBITER_OVF_EN
        logic                   ovf;
`endif
        id_t                    id;
    } s2_t;

endpackage
`default_nettype wire

// File: rtl/add_arbiter_prefix.sv
`default_nettype none
// ============================================================================
//  Module      : prefix_add64
//  Description : Combinational parallel-prefix (Kogge-Stone) adder with
//                carry-out and carry into the most significant bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module prefix_add64
    import add_arbiter_pkg::*;
#(
    parameter int W = c_w_default
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W-1:0] w_p;
    logic [W-1:0] w_c;
    logic [W-1:0] w_gg;

    assign w_p = a ^ b;

    always_comb begin
        logic [W-1:0] w_g;
        logic [W-1:0] w_pp;
        logic [W-1:0] w_gn;
        logic [W-1:0] w_pn;
        // Fold carry-in into bit 0 so every group generate is a true carry-out.
        w_g    = a & b;
        w_g[0] = w_g[0] | (w_p[0] & cin);
        w_pp   = w_p;
        for (int d = 1; d < W; d = d * 2) begin
            w_gn = w_g;
            w_pn = w_pp;
            for (int i = 0; i < W; i++) begin
                if (i >= d) begin
                    w_gn[i] = w_g[i] | (w_pp[i] & w_g[i-d]);
                    w_pn[i] = w_pp[i] & w_pp[i-d];
                end
            end
            w_g  = w_gn;
            w_pp = w_pn;
        end
        w_gg   = w_g;
        w_c[0] = cin;
        for (int i = 1; i < W; i++) begin
            w_c[i] = w_g[i-1];
        end
    end

    assign s    = w_c ^ w_p;
    assign cout = w_gg[W-1];
    assign cmsb = w_c[W-1];

endmodule
`default_nettype wire

// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : add_arbiter
//  Description : Round-robin arbiter for two adder requesters feeding a
//                two-stage pipelined prefix adder with valid/ready output.
//                Define ADD_ARBITER_OVF_EN to add the signed-overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int W = c_w_default
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_s,
    output logic         res_cout,
    output logic         res_id
`ifdef ADD_ARBITER_OVF_EN
    ,
    output logic         res_ovf
`endif
);

    logic         w_advance;
    logic         w_grant_ok;
    logic         w_pick1;
    logic         w_xfer;
    logic         r_s1_valid;
    logic         r_res_valid;
    logic         r_last_grant;
    s1_t          r_s1;
    s1_t          w_s1_next;
    s2_t          r_s2;
    s2_t          w_s2_next;
    logic [W-1:0] w_sum;
    logic         w_cout;
    logic         w_cmsb;

    assign w_advance  = !r_res_valid || res_ready;
    // Stage 1 may refill whenever it is empty, even if the output is stalled.
    assign w_grant_ok = !rst && (w_advance || !r_s1_valid);
    assign w_pick1    = req1_valid && (!req0_valid || !r_last_grant);
    assign req0_ready = w_grant_ok && !w_pick1;
    assign req1_ready = w_grant_ok && w_pick1;
    assign w_xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_comb begin
        w_s1_next     = '0;
        w_s1_next.a   = c_w_default'(w_pick1 ? req1_a : req0_a);
        w_s1_next.b   = c_w_default'(w_pick1 ? req1_b : req0_b);
        w_s1_next.cin = w_pick1 ? req1_cin : req0_cin;
        w_s1_next.id  = w_pick1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_xfer) begin
            r_s1_valid <= 1'b1;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_s1 <= w_s1_next;
        end
    end

    prefix_add64 #(
        .W    (W)
    ) u_adder (
        .a    (r_s1.a[W-1:0]),
        .b    (r_s1.b[W-1:0]),
        .cin  (r_s1.cin),
        .s    (w_sum),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    always_comb begin
        w_s2_next      = '0;
        w_s2_next.s    = c_w_default'(w_sum);
        w_s2_next.cout = w_cout;
        w_s2_next.id   = r_s1.id;
`ifdef ADD_ARBITER_OVF_EN
        w_s2_next.ovf  = w_cmsb ^ w_cout;
`endif
    end

`ifdef ADD_ARBITER_OVF_EN
    assign res_ovf = r_s2.ovf;
`else
    logic w_unused_cmsb;
    assign w_unused_cmsb = w_cmsb;
`endif

    // last_grant resets to 1 so req0 wins the first contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid  <= 1'b0;
            r_s2         <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_advance) begin
                r_res_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2 <= w_s2_next;
                end
            end
            if (w_xfer) begin
                r_last_grant <= w_pick1;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_s     = r_s2.s[W-1:0];
    assign res_cout  = r_s2.cout;
    assign res_id    = r_s2.id;

endmodule
`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_arbiter
//  Description : Self-checking bench for add_arbiter: vector table, scoreboard
//                and hand-written contest / backpressure / reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         res_valid, res_ready;
    logic [W-1:0] res_s;
    logic         res_cout, res_id;
`ifdef ADD_ARBITER_OVF_EN
    logic         res_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_s      (res_s),
        .res_cout   (res_cout),
        .res_id     (res_id)
`ifdef ADD_ARBITER_OVF_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        id;
    } exp_t;

    typedef struct {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t vt[10];

    function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic cin, logic id);
        logic [64:0] t;
        exp_t        e;
        t      = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        e.s    = t[63:0];
        e.cout = t[64];
        e.ovf  = (a[63] == b[63]) && (t[63] != a[63]);
        e.id   = id;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || res_valid) && n < 20) begin
            tick();
            n++;
        end
        chk(name, {63'd0, (sb_q.size() == 0) && !res_valid}, 64'd1);
    endtask

    // Scoreboard: push on accepted requests, pop on accepted results.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL ready_excl: got both ready high, required at most one");
            end
            if (res_valid && res_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got s=%h id=%0d, required no result", res_s, res_id);
                end else begin
                    sb_e = sb_q.pop_front();
                    if (res_s !== sb_e.s || res_cout !== sb_e.cout || res_id !== sb_e.id
`ifdef ADD_ARBITER_OVF_EN
                        || res_ovf !== sb_e.ovf
`endif
                    ) begin
                        errors++;
                        $display("FAIL sb_result: got s=%h c=%0d id=%0d, required s=%h c=%0d id=%0d",
                                 res_s, res_cout, res_id, sb_e.s, sb_e.cout, sb_e.id);
                    end
                end
            end
            if (req0_valid && req0_ready) sb_q.push_back(model(req0_a, req0_b, req0_cin, 1'b0));
            if (req1_valid && req1_ready) sb_q.push_back(model(req1_a, req1_b, req1_cin, 1'b1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rdy;
        logic        exp_id;
        int          nacc;
        logic [66:0] snap;

        vt[0] = '{1'b0, 64'd29, 64'd5, 1'b0, 64'd34, 1'b0, 1'b0};
        vt[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vt[3] = '{1'b1, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0};
        vt[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vt[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0};
        vt[7] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vt[8] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vt[9] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

        rst = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        tick();
        tick();
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res_s", res_s, 64'd0);
        chk("rst_res_cout", {63'd0, res_cout}, 64'd0);
        chk("rst_res_id", {63'd0, res_id}, 64'd0);
        chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
        chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Vector table: one isolated transfer each, 2-cycle latency checked.
        for (int i = 0; i < 10; i++) begin
            if (vt[i].id) begin
                req1_valid = 1'b1; req1_a = vt[i].a; req1_b = vt[i].b; req1_cin = vt[i].cin;
            end else begin
                req0_valid = 1'b1; req0_a = vt[i].a; req0_b = vt[i].b; req0_cin = vt[i].cin;
            end
            @(negedge clk);
            chk("tbl_ready", {63'd0, vt[i].id ? req1_ready : req0_ready}, 64'd1);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk("tbl_lat1_valid", {63'd0, res_valid}, 64'd0);
            tick();
            chk("tbl_valid", {63'd0, res_valid}, 64'd1);
            chk("tbl_s", res_s, vt[i].s);
            chk("tbl_cout", {63'd0, res_cout}, {63'd0, vt[i].cout});
            chk("tbl_id", {63'd0, res_id}, {63'd0, vt[i].id});
`ifdef ADD_ARBITER_OVF_EN
            chk("tbl_ovf", {63'd0, res_ovf}, {63'd0, vt[i].ovf});
`endif
            tick();
            chk("tbl_clear", {63'd0, res_valid}, 64'd0);
        end

        // Contest: both valid every cycle, alternating grants, one result per cycle.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_cin = 1'b0;
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_cin = 1'b1;
        exp_id = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            if (k >= 2) begin
                chk("contest_valid", {63'd0, res_valid}, 64'd1);
                chk("contest_id", {63'd0, res_id}, {63'd0, exp_id});
                exp_id = ~exp_id;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("contest_drain");

        // Backpressure: output stalled, req1 streaming.
        do_reset();
        res_ready = 1'b0;
        req1_valid = 1'b1;
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_cin = 1'b0;
        nacc = 0;
        snap = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rdy = req1_ready;
            chk("bp_ready", {63'd0, rdy}, (k < 2) ? 64'd1 : 64'd0);
            if (rdy) nacc++;
            tick();
            if (rdy) begin
                req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            end
            if (k == 1) begin
                snap = {res_valid, res_cout, res_id, res_s};
                chk("bp_stall_valid", {63'd0, res_valid}, 64'd1);
            end else if (k > 1) begin
                chk("bp_stable", snap[63:0], res_s);
                chk("bp_stable_ctl", {61'd0, snap[66:64]}, {61'd0, res_valid, res_cout, res_id});
            end
        end
        chk("bp_accepts", nacc, 64'd2);
        req1_valid = 1'b0;
        res_ready = 1'b1;
        drain("bp_drain");

        // Reset mid-flight with both stages occupied.
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 64'd100; req0_b = 64'd1; req0_cin = 1'b0;
        req1_a = 64'd200; req1_b = 64'd2; req1_cin = 1'b0;
        tick();
        tick();
        chk("mf_pre_valid", {63'd0, res_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mf_rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("mf_rst_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        rst = 1'b0;
        chk("mf_post_valid", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        chk("mf_winner0", {63'd0, req0_ready}, 64'd1);
        chk("mf_winner1", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("mf_no_stale", {63'd0, res_valid}, 64'd0);
        tick();
        chk("mf_first_valid", {63'd0, res_valid}, 64'd1);
        chk("mf_first_id", {63'd0, res_id}, 64'd0);
        chk("mf_first_s", res_s, 64'd101);
        tick();
        chk("mf_end_clear", {63'd0, res_valid}, 64'd0);
        drain("mf_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
